// File: rtl/jk_ff_bank_pkg.sv
// Shared definitions for the JK flip-flop bank: mode encodings and the mode type.
// Every module in the bank imports this package so the encodings are defined once.
package jk_ff_bank_pkg;

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DN   = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    localparam int MODE_W = 2;

endpackage : jk_ff_bank_pkg

// File: rtl/jk_ff_bank_jk_cell.sv
// Single JK flip-flop with synchronous reset to a per-cell value and a clock enable.
// Reset has priority over the enable; qb is always the inverse of the stored bit.
module jk_cell (
    input  logic clk,
    input  logic sync_reset,
    input  logic rst_val,
    input  logic ce,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (ce) begin
            unique case ({j, k})
                2'b00:   q_d = q_q;
                2'b01:   q_d = 1'b0;
                2'b10:   q_d = 1'b1;
                2'b11:   q_d = ~q_q;
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            q_q <= rst_val;
        end else begin
            q_q <= q_d;
        end
    end

    // qb is derived from q every cycle, so the pair can never drift apart.
    assign q  = q_q;
    assign qb = ~q_q;

endmodule : jk_cell

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH JK cells with per-mode J/K steering: independent JK, up/down count, parallel load.
// There is no handshake: every edge with en=1 consumes j/k/d/mode, and q/qb/tc are always valid.
module jk_ff_bank
    import jk_ff_bank_pkg::*;
#(
    parameter int                WIDTH   = 4,
    parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              sync_reset,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  j,
    input  logic [WIDTH-1:0]  k,
    input  logic [WIDTH-1:0]  d,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  qb,
    output logic              tc
);

    mode_t             mode_s;
    logic [WIDTH-1:0]  q_w;
    logic [WIDTH-1:0]  qb_w;
    logic [WIDTH-1:0]  up_tog;
    logic [WIDTH-1:0]  dn_tog;
    logic [WIDTH-1:0]  j_s;
    logic [WIDTH-1:0]  k_s;

    assign mode_s = mode_t'(mode);

    // Bit i toggles when all lower bits are 1 (carry) or all 0 (borrow); bit 0 always toggles.
    always_comb begin
        up_tog = '0;
        dn_tog = '0;
        for (int i = 0; i < WIDTH; i++) begin
            up_tog[i] = 1'b1;
            dn_tog[i] = 1'b1;
            for (int b = 0; b < i; b++) begin
                up_tog[i] = up_tog[i] & q_w[b];
                dn_tog[i] = dn_tog[i] & ~q_w[b];
            end
        end
    end

    always_comb begin
        j_s = '0;
        k_s = '0;
        unique case (mode_s)
            MODE_JK: begin
                j_s = j;
                k_s = k;
            end
            MODE_UP: begin
                j_s = up_tog;
                k_s = up_tog;
            end
            MODE_DN: begin
                j_s = dn_tog;
                k_s = dn_tog;
            end
            MODE_LOAD: begin
                j_s = d;
                k_s = ~d;
            end
            default: begin
                j_s = '0;
                k_s = '0;
            end
        endcase
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk        (clk),
            .sync_reset (sync_reset),
            .rst_val    (RST_VAL[g]),
            .ce         (en),
            .j          (j_s[g]),
            .k          (k_s[g]),
            .q          (q_w[g]),
            .qb         (qb_w[g])
        );
    end

    // Terminal count looks only at q and mode, so it stays visible while en is low.
    always_comb begin
        tc = 1'b0;
        unique case (mode_s)
            MODE_UP: tc = &q_w;
            MODE_DN: tc = ~|q_w;
            default: tc = 1'b0;
        endcase
    end

    assign q  = q_w;
    assign qb = qb_w;

endmodule : jk_ff_bank

// File: tb/tb_jk_ff_bank.sv
// Bench for jk_ff_bank: three instances (WIDTH=4 RST_VAL=5, WIDTH=4 RST_VAL=0, WIDTH=1 RST_VAL=1)
// share one stimulus stream; expected results from an arithmetic model are queued and checked.
module tb_jk_ff_bank;

    logic       clk;
    logic       sync_reset;
    logic       en;
    logic [1:0] mode;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] d;

    logic [3:0] qa, qba, qz, qbz;
    logic       tca, tcz;
    logic [0:0] q1, qb1;
    logic       tc1;

    int n_tests;
    int n_fail;

    // Entry layout: {qa[3:0], tca, qz[3:0], tcz, q1, tc1}
    logic [11:0] exp_q[$];

    int unsigned ma, mz, m1;

    jk_ff_bank #(.WIDTH(4), .RST_VAL(4'h5)) dut_a (
        .clk(clk), .sync_reset(sync_reset), .en(en), .mode(mode),
        .j(j), .k(k), .d(d), .q(qa), .qb(qba), .tc(tca)
    );

    jk_ff_bank #(.WIDTH(4), .RST_VAL(4'h0)) dut_z (
        .clk(clk), .sync_reset(sync_reset), .en(en), .mode(mode),
        .j(j), .k(k), .d(d), .q(qz), .qb(qbz), .tc(tcz)
    );

    jk_ff_bank #(.WIDTH(1), .RST_VAL(1'b1)) dut_1 (
        .clk(clk), .sync_reset(sync_reset), .en(en), .mode(mode),
        .j(j[0:0]), .k(k[0:0]), .d(d[0:0]), .q(q1), .qb(qb1), .tc(tc1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned model_next(input int unsigned cur, input int width,
                                               input int unsigned rv, input logic r,
                                               input logic e, input logic [1:0] m,
                                               input logic [3:0] jj, input logic [3:0] kk,
                                               input logic [3:0] dd);
        int unsigned modulus;
        int unsigned nxt;
        modulus = 1 << width;
        if (r) return rv;
        if (!e) return cur;
        case (m)
            2'b01: nxt = (cur + 1) % modulus;
            2'b10: nxt = (cur + modulus - 1) % modulus;
            2'b11: nxt = dd % modulus;
            default: begin
                nxt = cur;
                for (int b = 0; b < width; b++) begin
                    if (jj[b] && kk[b])      nxt = nxt ^ (1 << b);
                    else if (jj[b])          nxt = nxt | (1 << b);
                    else if (kk[b])          nxt = nxt & ~(1 << b);
                end
            end
        endcase
        return nxt;
    endfunction

    function automatic logic model_tc(input int unsigned cur, input int width, input logic [1:0] m);
        if (m == 2'b01) return cur == (1 << width) - 1;
        if (m == 2'b10) return cur == 0;
        return 1'b0;
    endfunction

    task automatic drive(input logic r, input logic e, input logic [1:0] m,
                         input logic [3:0] jj, input logic [3:0] kk, input logic [3:0] dd);
        logic [3:0] ea, ez;
        logic       e1;
        @(negedge clk);
        sync_reset = r;
        en         = e;
        mode       = m;
        j          = jj;
        k          = kk;
        d          = dd;
        ma = model_next(ma, 4, 5, r, e, m, jj, kk, dd);
        mz = model_next(mz, 4, 0, r, e, m, jj, kk, dd);
        m1 = model_next(m1, 1, 1, r, e, m, jj, kk, dd);
        ea = ma[3:0];
        ez = mz[3:0];
        e1 = m1[0];
        exp_q.push_back({ea, model_tc(ma, 4, m), ez, model_tc(mz, 4, m), e1, model_tc(m1, 1, m)});
    endtask

    // Change mode between edges with en low and check tc reacts without a clock edge.
    task automatic tc_mode_check(input logic [1:0] m);
        @(negedge clk);
        sync_reset = 1'b0;
        en         = 1'b0;
        mode       = m;
        #1;
        check("tc_comb_a", {3'b0, tca}, {3'b0, model_tc(ma, 4, m)});
        check("tc_comb_1", {3'b0, tc1}, {3'b0, model_tc(m1, 1, m)});
    endtask

    always @(posedge clk) begin
        logic [11:0] e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("q_a",   qa,            e[11:8]);
            check("qb_a",  qba,           ~e[11:8]);
            check("tc_a",  {3'b0, tca},   {3'b0, e[7]});
            check("q_z",   qz,            e[6:3]);
            check("qb_z",  qbz,           ~e[6:3]);
            check("tc_z",  {3'b0, tcz},   {3'b0, e[2]});
            check("q_1",   {3'b0, q1},    {3'b0, e[1]});
            check("qb_1",  {3'b0, qb1},   {3'b0, ~e[1]});
            check("tc_1",  {3'b0, tc1},   {3'b0, e[0]});
        end
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        sync_reset = 1'b0;
        en         = 1'b0;
        mode       = 2'b00;
        j          = '0;
        k          = '0;
        d          = '0;
        ma = 0;
        mz = 0;
        m1 = 0;

        // Reset with en=1 in UP mode, then three up-counts (dut_a: 5 -> 8).
        drive(1, 1, 2'b01, 4'h0, 4'h0, 4'h0);
        repeat (3) drive(0, 1, 2'b01, 4'h0, 4'h0, 4'h0);

        // JK mode from zero.
        drive(0, 1, 2'b11, 4'h0, 4'h0, 4'h0);
        drive(0, 1, 2'b00, 4'b1010, 4'b0000, 4'h0);
        drive(0, 1, 2'b00, 4'b1111, 4'b1111, 4'h0);
        drive(0, 1, 2'b00, 4'b0000, 4'b0100, 4'h0);

        // Up wrap from E.
        drive(0, 1, 2'b11, 4'h0, 4'h0, 4'hE);
        repeat (2) drive(0, 1, 2'b01, 4'h0, 4'h0, 4'h0);

        // Down wrap from 1, then pause three edges.
        drive(0, 1, 2'b11, 4'h0, 4'h0, 4'h1);
        repeat (2) drive(0, 1, 2'b10, 4'h0, 4'h0, 4'h0);
        repeat (3) drive(0, 0, 2'b10, 4'hF, 4'hF, 4'h3);
        tc_mode_check(2'b01);
        tc_mode_check(2'b00);
        tc_mode_check(2'b10);

        // Reset in the middle of a count, then resume.
        drive(1, 0, 2'b00, 4'h0, 4'h0, 4'h0);
        repeat (6) drive(0, 1, 2'b01, 4'h0, 4'h0, 4'h0);
        drive(1, 1, 2'b01, 4'hF, 4'hF, 4'hF);
        repeat (2) drive(0, 1, 2'b01, 4'h0, 4'h0, 4'h0);

        // Randomised traffic across all modes, enables and occasional resets.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 4'($urandom));
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain actual=%0d expected=0 entries left", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_jk_ff_bank

// File: doc/jk_ff_bank.md
# jk_ff_bank

Parametrised bank of WIDTH synchronous JK flip-flops sharing one clock, with a synchronous active-high reset to a programmable value and a clock enable. Beyond per-bit JK operation, the block has a counter mode and a parallel-load mode. In counter mode the cells are chained as a synchronous binary up/down counter, with J=K driven by the carry or borrow of the lower bits. It is the general-purpose successor to the single-bit JK flip-flop, for register banks, small counters and toggle arrays.

## Interface
- WIDTH, 4: number of JK cells. Must be at least 1.
- RST_VAL, {WIDTH{1'b0}}: value loaded into q on sync_reset.
- clk  input  1  clock; all state changes on its rising edge.
- sync_reset  input  1  synchronous, active-high reset. It has priority over every other input.
- en  input  1  clock enable. When low, q holds.
- mode  input  2  operating mode (encodings under Operation).
- j  input  WIDTH  per-bit J inputs, used in JK mode only.
- k  input  WIDTH  per-bit K inputs, used in JK mode only.
- d  input  WIDTH  parallel load data, used in LOAD mode only.
- q  output  WIDTH  registered state.
- qb  output  WIDTH  always exactly ~q, including during and after reset.
- tc  output  1  terminal count. Combinational from q and mode.

One clock. Reset is synchronous and active-high; the ports are named clk and sync_reset.

## Operation
- Priority at each rising edge of clk: sync_reset, then !en, then mode.
- sync_reset=1: q<=RST_VAL and qb<=~RST_VAL. mode, en, j, k and d are ignored.
- en=0 with sync_reset=0: q holds, in every mode.
- MODE_JK (2'b00): each bit i follows the JK rule independently.
  - j=0, k=0: hold.
  - j=0, k=1: q[i]<=0.
  - j=1, k=0: q[i]<=1.
  - j=1, k=1: q[i]<=~q[i].
- MODE_UP (2'b01): synchronous up-count.
  - Bit i toggles iff q[i-1:0] are all 1. Bit 0 always toggles.
  - All ones wraps to all zeros.
- MODE_DN (2'b10): synchronous down-count.
  - Bit i toggles iff q[i-1:0] are all 0.
  - All zeros wraps to all ones.
- MODE_LOAD (2'b11): q<=d.
- Count modes are realised through the cells' J=K toggle path, not by a behavioural adder. Arithmetic is modulo 2^WIDTH, with no saturation and no overflow flag other than tc.
- tc:
  - 1 in MODE_UP when q is all ones.
  - 1 in MODE_DN when q is all zeros.
  - 0 in MODE_JK and MODE_LOAD.
  - Independent of en, so tc can be seen while the bank is paused.
- qb is never derived from its own previous value. It always equals ~q, so q and qb cannot diverge.

## Timing
- Latency: inputs sampled at rising edge N appear on q and qb after edge N, i.e. one cycle.
- tc is combinational from q and mode. A change of mode changes tc in the same cycle, with no clock edge.
- Reset values: q=RST_VAL, qb=~RST_VAL, tc = f(RST_VAL, mode). Before the first reset, q is X in RTL. The bench must reset first.
- sync_reset asserted mid-count: the next edge loads RST_VAL and the count sequence restarts from RST_VAL once reset is released.
- Simultaneous sync_reset and en, with any mode: reset wins.
- Mode change between edges: the edge uses the mode sampled at that edge. Count state is q itself, so no hidden state is lost.
- WIDTH=1: up and down counting both reduce to toggling every enabled cycle. tc is q in MODE_UP and ~q in MODE_DN.

## Structure
- A shared package holds:
  - the mode encodings MODE_JK, MODE_UP, MODE_DN and MODE_LOAD;
  - a 2-bit typedef for mode.
- Sub-module jk_cell is a single JK flip-flop with:
  - ports clk, sync_reset, rst_val, ce, j, k, q and qb;
  - reset taking priority over ce.
- jk_ff_bank generates WIDTH jk_cell instances and contains the combinational J/K steering per mode:
  - JK mode: the j and k inputs.
  - Count modes: the carry or borrow chain.
  - LOAD mode: j=d and k=~d.
- jk_ff_bank also generates tc.

## Test plan
All scenarios use WIDTH=4.
- Reset: RST_VAL=4'h5. Assert sync_reset for 1 edge with en=1, mode=UP -> q=4'h5, qb=4'hA. Release, then 3 edges -> q=4'h8.
- JK mode: from q=4'h0, apply j=4'b1010, k=4'b0000 -> q=4'hA. Then j=4'b1111, k=4'b1111 -> q=4'h5. Then j=0, k=4'b0100 -> q=4'h1. qb=~q throughout.
- Up wrap: load d=4'hE, then mode=UP for 2 edges -> q=4'hF with tc=1, then q=4'h0 with tc=0.
- Down wrap: load d=4'h1, then mode=DN -> q=4'h0 with tc=1, next edge q=4'hF. Hold en=0 for 3 edges -> q stays 4'hF. Switch mode to JK -> tc=0 combinationally.
- Reset mid-count: RST_VAL=4'h0, count up to 4'h6. Assert sync_reset with en=1 -> q=4'h0 at the next edge, ignoring the count. On release, counting resumes 4'h1, 4'h2.
- WIDTH=1 instance: mode=UP, en=1 -> q toggles every edge and tc equals q.
